// File: rtl/ddfs_phase_ctrl_if.sv
// ----------------------------------------------------------------------------
// ddfs_phase_ctrl_if
// Frequency-tuning-word handshake between the control/register side and the
// DDFS phase controller.
//   ftw_in    : new tuning word (held by the source until accepted)
//   ftw_valid : ftw_in is valid
//   ftw_ready : controller can accept a word; transfer on valid && ready
// Modports:
//   master : control side (drives ftw_in / ftw_valid)
//   slave  : phase controller (drives ftw_ready)
// ----------------------------------------------------------------------------
interface ddfs_phase_ctrl_if #(
  parameter int ACC_W = 24
) ();
  logic [ACC_W-1:0] ftw_in;
  logic             ftw_valid;
  logic             ftw_ready;

  modport master (output ftw_in, output ftw_valid, input ftw_ready);
  modport slave  (input ftw_in, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/ddfs_phase_ctrl.sv
// ----------------------------------------------------------------------------
// ddfs_phase_ctrl
// Phase-accumulator controller for the DDFS waveform LUT. Holds the frequency
// tuning word, steps the accumulator every RUN cycle, drives the registered
// LUT address and registers the LUT data as the output sample.
//
// Optional build macro: DDFS_SWEEP_EN
//   defined   : linear chirp, FTW += sweep_step on every wrap (clamped to
//               sweep_limit) unless a pending handshake word takes priority
//   undefined : sweep_step / sweep_limit ignored, no sweep logic
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start, stop   : level controls; stop has priority
//   ftw_if        : FTW valid/ready handshake (slave modport)
//   phase_off     : static phase offset added to the LUT address
//   lut_address   : registered LUT address
//   lut_q         : LUT combinational data
//   sample_out    : registered sample, one cycle after its address
//   sample_valid  : sample_out valid
//   busy          : high while running
//   wrap          : one-cycle pulse on accumulator carry-out
//   sweep_step    : FTW increment per wrap (sweep build only)
//   sweep_limit   : FTW ceiling (sweep build only)
// ----------------------------------------------------------------------------
module ddfs_phase_ctrl #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  ddfs_phase_ctrl_if.slave  ftw_if,
  input  logic [ADDR_W-1:0] phase_off,
  output logic [ADDR_W-1:0] lut_address,
  input  logic [DATA_W-1:0] lut_q,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              wrap,
  input  logic [ACC_W-1:0]  sweep_step,
  input  logic [ACC_W-1:0]  sweep_limit
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  ftw_q;
  logic [ACC_W-1:0]  pend_q;
  logic              pend_vld_q;
  logic              ftw_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_vld_q;
  logic [DATA_W-1:0] sample_q;
  logic              sample_vld_q;
  logic              busy_q;
  logic              wrap_q;

  logic [ACC_W:0]    sum_d;
  logic [ADDR_W-1:0] addr_d;
  logic              xfer_d;

  // Accumulator step with carry; the top ADDR_W bits of the new phase plus
  // the offset form the next address (wraps modulo 2^ADDR_W).
  always_comb begin
    sum_d  = {1'b0, acc_q} + {1'b0, ftw_q};
    addr_d = sum_d[ACC_W-1 -: ADDR_W] + phase_off;
    xfer_d = ftw_if.ftw_valid && ftw_ready_q;
  end

`ifdef DDFS_SWEEP_EN
  logic [ACC_W:0]   sweep_sum_d;
  logic [ACC_W-1:0] sweep_d;

  // One extra bit so an overflowing increment still compares above the limit.
  always_comb begin
    sweep_sum_d = {1'b0, ftw_q} + {1'b0, sweep_step};
    if (sweep_sum_d > {1'b0, sweep_limit}) begin
      sweep_d = sweep_limit;
    end else begin
      sweep_d = sweep_sum_d[ACC_W-1:0];
    end
  end
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_step, sweep_limit};
`endif

  // Pending word storage: data only, qualified by pend_vld_q.
  always_ff @(posedge clk) begin
    if (state_q == RUN && !stop && xfer_d) begin
      pend_q <= ftw_if.ftw_in;
    end
  end

  // Stage p0: control FSM, accumulator and address; stage p1: sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_q        <= '0;
      pend_vld_q   <= 1'b0;
      ftw_ready_q  <= 1'b1;
      addr_q       <= '0;
      addr_vld_q   <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      sample_q     <= lut_q;
      sample_vld_q <= addr_vld_q;
      case (state_q)
        IDLE: begin
          wrap_q <= 1'b0;
          if (xfer_d) begin
            ftw_q <= ftw_if.ftw_in;
          end
          if (start && !stop) begin
            state_q    <= RUN;
            acc_q      <= '0;
            addr_q     <= phase_off;
            addr_vld_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            // Phase, FTW and address freeze; a waiting word lands now.
            state_q     <= IDLE;
            addr_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            ftw_ready_q <= 1'b1;
            if (pend_vld_q) begin
              ftw_q <= pend_q;
            end else if (xfer_d) begin
              ftw_q <= ftw_if.ftw_in;
            end
          end else begin
            acc_q  <= sum_d[ACC_W-1:0];
            wrap_q <= sum_d[ACC_W];
            addr_q <= addr_d;
            if (sum_d[ACC_W] && pend_vld_q) begin
              // New word applies from the add after the wrap: phase-continuous.
              ftw_q       <= pend_q;
              pend_vld_q  <= 1'b0;
              ftw_ready_q <= 1'b1;
            end else begin
`ifdef DDFS_SWEEP_EN
              if (sum_d[ACC_W]) begin
                ftw_q <= sweep_d;
              end
`endif
              if (xfer_d) begin
                pend_vld_q  <= 1'b1;
                ftw_ready_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lut_address      = addr_q;
  assign sample_out       = sample_q;
  assign sample_valid     = sample_vld_q;
  assign busy             = busy_q;
  assign wrap             = wrap_q;
  assign ftw_if.ftw_ready = ftw_ready_q;

endmodule

// File: tb/tb_ddfs_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddfs_phase_ctrl
// Directed bench for ddfs_phase_ctrl. The LUT is a sawtooth modelled as
// lut_q = lut_address % 11. Build with +define+DDFS_SWEEP_EN to add the
// chirp scenario.
// ----------------------------------------------------------------------------
module tb_ddfs_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  phase_off = '0;
  logic [7:0]  lut_address;
  logic [7:0]  lut_q;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        busy;
  logic        wrap;
  logic [23:0] sweep_step = '0;
  logic [23:0] sweep_limit = 24'hFFFFFF;

  int n_cmp = 0;
  int n_err = 0;

  ddfs_phase_ctrl_if #(.ACC_W(24)) fif ();

  ddfs_phase_ctrl #(.ACC_W(24), .ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .ftw_if       (fif.slave),
    .phase_off    (phase_off),
    .lut_address  (lut_address),
    .lut_q        (lut_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .wrap         (wrap),
    .sweep_step   (sweep_step),
    .sweep_limit  (sweep_limit)
  );

  always #5 clk = ~clk;

  assign lut_q = 8'(int'(lut_address) % 11);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [23:0] w);
    fif.ftw_valid = 1'b1;
    fif.ftw_in    = w;
    step();
    fif.ftw_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    fif.ftw_valid = 1'b0;
    fif.ftw_in    = '0;
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (lut_address !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %0h want 0", lut_address); end
    n_cmp++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL reset_sample: got %0h want 0", sample_out); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_svalid: got %0b want 0", sample_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    n_cmp++; if (fif.ftw_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", fif.ftw_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sawtooth();
    logic [7:0] ea, es;
    phase_off = 8'd0;
    load_idle(24'h010000);
    do_start();
    n_cmp++; if (lut_address !== 8'h00) begin n_err++; $display("FAIL saw_first_addr: got %0h want 0", lut_address); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL saw_busy: got %0b want 1", busy); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL saw_svalid0: got %0b want 0", sample_valid); end
    for (int k = 1; k <= 260; k++) begin
      step();
      ea = 8'(k % 256);
      es = 8'(((k - 1) % 256) % 11);
      n_cmp++; if (lut_address !== ea) begin n_err++; $display("FAIL saw_addr k=%0d: got %0h want %0h", k, lut_address, ea); end
      n_cmp++; if (sample_out !== es) begin n_err++; $display("FAIL saw_sample k=%0d: got %0h want %0h", k, sample_out, es); end
      n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL saw_svalid k=%0d: got %0b want 1", k, sample_valid); end
      n_cmp++; if (wrap !== (k == 256)) begin n_err++; $display("FAIL saw_wrap k=%0d: got %0b want %0b", k, wrap, (k == 256)); end
    end
    do_stop();
    n_cmp++; if (lut_address !== 8'd4) begin n_err++; $display("FAIL saw_stop_hold: got %0h want 4", lut_address); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL saw_stop_busy: got %0b want 0", busy); end
    step();
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL saw_stop_svalid: got %0b want 0", sample_valid); end
    n_cmp++; if (lut_address !== 8'd4) begin n_err++; $display("FAIL saw_stop_hold2: got %0h want 4", lut_address); end
  endtask

  task automatic test_phase_off();
    logic [7:0] ea;
    phase_off = 8'd3;
    load_idle(24'h100000);
    do_start();
    n_cmp++; if (lut_address !== 8'd3) begin n_err++; $display("FAIL poff_first: got %0h want 3", lut_address); end
    for (int k = 1; k <= 34; k++) begin
      step();
      ea = 8'((16 * k + 3) % 256);
      n_cmp++; if (lut_address !== ea) begin n_err++; $display("FAIL poff_addr k=%0d: got %0h want %0h", k, lut_address, ea); end
      n_cmp++; if (wrap !== (k % 16 == 0)) begin n_err++; $display("FAIL poff_wrap k=%0d: got %0b want %0b", k, wrap, (k % 16 == 0)); end
    end
    do_stop();
    phase_off = 8'd0;
  endtask

  task automatic test_ftw_update();
    load_idle(24'h010000);
    do_start();
    for (int k = 1; k <= 100; k++) step();
    n_cmp++; if (lut_address !== 8'd100) begin n_err++; $display("FAIL upd_pre: got %0h want 64", lut_address); end
    fif.ftw_valid = 1'b1;
    fif.ftw_in    = 24'h020000;
    step();
    fif.ftw_valid = 1'b0;
    n_cmp++; if (fif.ftw_ready !== 1'b0) begin n_err++; $display("FAIL upd_ready_drop: got %0b want 0", fif.ftw_ready); end
    n_cmp++; if (lut_address !== 8'd101) begin n_err++; $display("FAIL upd_addr101: got %0h want 65", lut_address); end
    for (int k = 102; k <= 255; k++) begin
      step();
      n_cmp++; if (fif.ftw_ready !== 1'b0 || lut_address !== 8'(k)) begin
        n_err++; $display("FAIL upd_wait k=%0d: ready %0b addr %0h want ready 0 addr %0h", k, fif.ftw_ready, lut_address, 8'(k));
      end
    end
    step();
    n_cmp++; if (lut_address !== 8'd0 || wrap !== 1'b1) begin n_err++; $display("FAIL upd_wrap: addr %0h wrap %0b want 0/1", lut_address, wrap); end
    n_cmp++; if (fif.ftw_ready !== 1'b1) begin n_err++; $display("FAIL upd_ready_back: got %0b want 1", fif.ftw_ready); end
    step();
    n_cmp++; if (lut_address !== 8'd2) begin n_err++; $display("FAIL upd_step2a: got %0h want 2", lut_address); end
    step();
    n_cmp++; if (lut_address !== 8'd4) begin n_err++; $display("FAIL upd_step2b: got %0h want 4", lut_address); end
    do_stop();
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (busy !== 1'b0 || sample_valid !== 1'b0) begin n_err++; $display("FAIL both_idle k=%0d: busy %0b svalid %0b want 0/0", k, busy, sample_valid); end
    end
    start = 1'b0;
    stop  = 1'b0;
    do_start();
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (lut_address !== 8'd10) begin n_err++; $display("FAIL ss_run: got %0h want a", lut_address); end
    do_stop();
    n_cmp++; if (lut_address !== 8'd10 || busy !== 1'b0 || sample_valid !== 1'b1) begin
      n_err++; $display("FAIL ss_stop: addr %0h busy %0b svalid %0b want a/0/1", lut_address, busy, sample_valid);
    end
    step();
    n_cmp++; if (sample_valid !== 1'b0 || lut_address !== 8'd10) begin n_err++; $display("FAIL ss_after: svalid %0b addr %0h want 0/a", sample_valid, lut_address); end
  endtask

  task automatic test_boundary();
    logic [7:0] ea;
    load_idle(24'hFF0000);
    do_start();
    for (int k = 1; k <= 4; k++) begin
      step();
      ea = 8'((256 - k) % 256);
      n_cmp++; if (lut_address !== ea || wrap !== (k >= 2)) begin
        n_err++; $display("FAIL alias k=%0d: addr %0h wrap %0b want %0h/%0b", k, lut_address, wrap, ea, (k >= 2));
      end
    end
    do_stop();
    load_idle(24'h000000);
    do_start();
    fif.ftw_valid = 1'b1;
    fif.ftw_in    = 24'h030000;
    step();
    fif.ftw_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (lut_address !== 8'd0 || wrap !== 1'b0 || fif.ftw_ready !== 1'b0) begin
        n_err++; $display("FAIL zero_ftw k=%0d: addr %0h wrap %0b ready %0b want 0/0/0", k, lut_address, wrap, fif.ftw_ready);
      end
    end
    do_stop();
    n_cmp++; if (fif.ftw_ready !== 1'b1) begin n_err++; $display("FAIL zero_stop_ready: got %0b want 1", fif.ftw_ready); end
    do_start();
    step();
    n_cmp++; if (lut_address !== 8'd3) begin n_err++; $display("FAIL zero_pend_a: got %0h want 3", lut_address); end
    step();
    n_cmp++; if (lut_address !== 8'd6) begin n_err++; $display("FAIL zero_pend_b: got %0h want 6", lut_address); end
    do_stop();
  endtask

  task automatic test_reset_mid_run();
    load_idle(24'h010000);
    do_start();
    for (int k = 0; k < 10; k++) step();
    fif.ftw_valid = 1'b1;
    fif.ftw_in    = 24'h050000;
    step();
    fif.ftw_valid = 1'b0;
    n_cmp++; if (fif.ftw_ready !== 1'b0) begin n_err++; $display("FAIL mid_pending: got %0b want 0", fif.ftw_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (lut_address !== 8'h00 || sample_out !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: addr %0h sample %0h want 0/0", lut_address, sample_out); end
    n_cmp++; if (sample_valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ctrl: svalid %0b busy %0b wrap %0b want 0/0/0", sample_valid, busy, wrap);
    end
    n_cmp++; if (fif.ftw_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %0b want 1", fif.ftw_ready); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (fif.ftw_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %0b want 1", fif.ftw_ready); end
    do_start();
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (lut_address !== 8'd0 || wrap !== 1'b0) begin n_err++; $display("FAIL mid_ftw_zero k=%0d: addr %0h wrap %0b want 0/0", k, lut_address, wrap); end
    end
    do_stop();
  endtask

`ifdef DDFS_SWEEP_EN
  task automatic test_sweep();
    logic [7:0] prev, inc, einc;
    logic       ew;
    sweep_step  = 24'h010000;
    sweep_limit = 24'h040000;
    load_idle(24'h010000);
    do_start();
    prev = lut_address;
    for (int k = 1; k <= 600; k++) begin
      step();
      inc  = lut_address - prev;
      einc = (k <= 256) ? 8'd1 : (k <= 384) ? 8'd2 : (k <= 470) ? 8'd3 : 8'd4;
      n_cmp++; if (inc !== einc) begin n_err++; $display("FAIL sweep_inc k=%0d: got %0d want %0d", k, inc, einc); end
      if (k <= 470) begin
        ew = (k == 256) || (k == 384) || (k == 470);
        n_cmp++; if (wrap !== ew) begin n_err++; $display("FAIL sweep_wrap k=%0d: got %0b want %0b", k, wrap, ew); end
      end
      prev = lut_address;
    end
    do_stop();
    sweep_step  = '0;
    sweep_limit = 24'hFFFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_sawtooth();
    test_phase_off();
    test_ftw_update();
    test_start_stop();
    test_boundary();
    test_reset_mid_run();
`ifdef DDFS_SWEEP_EN
    test_sweep();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddfs_phase_ctrl.md
Name: ddfs_phase_ctrl

Overview:
Phase-accumulator controller that sequences the 8-bit waveform LUT of the DDFS.
- Holds the frequency tuning word (FTW) and steps a phase accumulator every clock.
- Drives the LUT address and registers the LUT output as the synthesized sample.
- Handles start/stop and phase-continuous FTW updates through a valid/ready handshake.
- Sits between the control/register interface and the LUT; the sample output feeds the DAC path.

Parameters:
ACC_W, 24, phase accumulator width (bits); must be > ADDR_W
ADDR_W, 8, LUT address width; top ADDR_W accumulator bits form the address
DATA_W, 8, LUT data / sample width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE, begins generation
stop  in  1  level; returns to IDLE, has priority over start
ftw_in  in  ACC_W  new tuning word
ftw_valid  in  1  ftw_in valid
ftw_ready  out  1  controller can accept an FTW
phase_off  in  ADDR_W  static phase offset added to address
lut_address  out  ADDR_W  LUT address, registered
lut_q  in  DATA_W  LUT combinational output
sample_out  out  DATA_W  registered sample
sample_valid  out  1  sample_out valid this cycle
busy  out  1  high in RUN
wrap  out  1  one-cycle pulse on accumulator carry-out
sweep_step  in  ACC_W  FTW increment per wrap (sweep only)
sweep_limit  in  ACC_W  FTW ceiling (sweep only)

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc=0; ftw_reg=0; pending empty; lut_address=0; sample_out=0; sample_valid=0; busy=0; wrap=0; ftw_ready=1.
- States IDLE, RUN.
- IDLE→RUN: start=1 and stop=0. Actions: acc<=0; lut_address<=phase_off; addr_valid<=1.
- RUN→IDLE: stop=1. Actions: addr_valid<=0. acc, ftw_reg and lut_address hold their values.
- RUN every cycle:
  - sum = acc + ftw_reg, computed ACC_W+1 bits wide.
  - acc <= sum[ACC_W-1:0]; wrap <= sum[ACC_W].
  - lut_address <= sum[ACC_W-1 -: ADDR_W] + phase_off, modulo 2^ADDR_W.
- Sample pipeline: sample_out <= lut_q and sample_valid <= addr_valid. Sample latency is 1 cycle after lut_address.
- busy = (state==RUN), registered.
- FTW handshake:
  - Transfer occurs when ftw_valid && ftw_ready.
  - In IDLE, ftw_reg <= ftw_in directly; ftw_ready stays 1.
  - In RUN, the word goes into a 1-entry pending register and ftw_ready drops to 0.
  - The pending word is copied to ftw_reg in the cycle wrap is generated, i.e. it takes effect from the next add (phase-continuous). Pending then clears and ftw_ready returns to 1 the next cycle.
  - stop while a word is pending: the word is copied to ftw_reg on entry to IDLE.
- Boundaries:
  - ftw_reg=0 in RUN: address constant, no wrap. A pending word then waits until stop.
  - ftw_reg ≥ 2^(ACC_W-1): address aliasing is allowed; no saturation.
  - start and stop in the same cycle: stop wins, stay or go IDLE.
  - rst_n asserted mid-RUN: immediate return to reset values; pending is lost.
  - ftw_valid held with ftw_ready=0: no transfer; ftw_in must be held by the source.

Optional Feature:
DDFS_SWEEP_EN:
- Defined: linear chirp. On every wrap with no pending word, ftw_reg <= min(ftw_reg + sweep_step, sweep_limit). The add uses ACC_W+1 bits, so an overflow clamps to sweep_limit. A pending word has priority over the sweep increment.
- Undefined: sweep_step and sweep_limit are ignored, no sweep logic is synthesized, and ftw_reg changes only via the handshake.

Test Plan:
1. Reset, FTW 0x010000 in IDLE, then start → lut_address 0,1,2,… one per cycle; sample_out lags by 1 cycle; against the sawtooth LUT sample_out reads 0..10,0,1…; first wrap pulse 256 cycles after start.
2. FTW 0x100000, phase_off=3 → lut_address 3,19,35,…, step 16; wrap every 16 cycles.
3. RUN at 0x010000, push 0x020000 mid-period → ftw_ready=0 until the wrap; from the add after the wrap, address steps by 2; no phase jump.
4. start and stop high together in IDLE → stays IDLE, busy=0, sample_valid=0. stop in RUN → sample_valid drops the next cycle, lut_address holds.
5. rst_n low mid-RUN with a word pending → all outputs 0 asynchronously; after release, ftw_ready=1 and ftw_reg=0.
6. DDFS_SWEEP_EN defined: FTW 0x010000, step 0x010000, limit 0x040000 → the address increment is 1 until the first wrap, then 2, 3, 4 after successive wraps, and stays 4.
